// File: rtl/conv_result_streamer.sv
// conv_result_streamer: captures a ROWSxCOLS result frame and drains it row-major over valid/ready; define RESULT_RELU_EN to rectify words at capture.
module conv_result_streamer #(
    parameter int ROWS = 6,
    parameter int COLS = 6,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_st,
    input  logic signed [W-1:0] din [0:ROWS-1][0:COLS-1],
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [W-1:0] m_data,
    output logic [2:0]          m_row,
    output logic [2:0]          m_col,
    output logic                m_last,
    output logic                busy,
    output logic                overrun
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;
    logic signed [W-1:0] frame [0:ROWS-1][0:COLS-1];
    logic [2:0] row, col;
    logic at_end, xfer, done, capture;
    function automatic logic signed [W-1:0] rect(input logic signed [W-1:0] v);
`ifdef RESULT_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction
    always_comb begin
        at_end   = (row == 3'(ROWS-1)) && (col == 3'(COLS-1));
        xfer     = (state == STREAM) && m_ready;
        done     = xfer && at_end;
        capture  = in_st && ((state == IDLE) || done);
        state_nx = capture ? STREAM : done ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // A strobe is only dropped when the frame in flight is not finishing this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row     <= '0;
            col     <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= in_st && (state == STREAM) && !done;
            if (capture || done) begin
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                col <= (col == 3'(COLS-1)) ? 3'd0 : col + 3'd1;
                row <= (col == 3'(COLS-1)) ? row + 3'd1 : row;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (capture)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    frame[r][c] <= rect(din[r][c]);
    end
    assign m_valid = (state == STREAM);
    assign busy    = m_valid;
    assign m_row   = row;
    assign m_col   = col;
    assign m_last  = m_valid && at_end;
    assign m_data  = m_valid ? frame[row][col] : '0;
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb_conv_result_streamer: queue-based scoreboard against a frame-level model of conv_result_streamer.
module tb_conv_result_streamer;
    logic clk = 0, reset = 0, in_st = 0, m_ready = 0;
    logic signed [15:0] din [0:5][0:5];
    logic m_valid, m_last, busy, overrun;
    logic signed [15:0] m_data;
    logic [2:0] m_row, m_col;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  r;
        logic [2:0]  c;
        logic        l;
    } item_t;

    item_t q[$];
    logic signed [15:0] pend_frame [0:5][0:5];
    bit pend, ovr_pend, ovr_exp, stall_prev;
    item_t held;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    conv_result_streamer dut (
        .clk(clk), .reset(reset), .in_st(in_st), .din(din),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last),
        .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic logic [15:0] ref_val(input logic signed [15:0] v);
`ifdef RESULT_RELU_EN
        return (v < 0) ? 16'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic push_frame();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                q.push_back('{d: ref_val(pend_frame[r][c]), r: 3'(r), c: 3'(c), l: (r == 5 && c == 5)});
    endtask

    // One clock of stimulus; a strobe is accepted only if nothing is outstanding or the last word leaves now.
    task automatic step(input logic s, input logic rdy);
        @(posedge clk);
        #1;
        if (pend) begin
            push_frame();
            pend = 0;
        end
        ovr_exp  = ovr_pend;
        ovr_pend = 0;
        in_st    = s;
        m_ready  = rdy;
        if (s) begin
            if (q.size() == 0 || (q.size() == 1 && rdy)) begin
                pend       = 1;
                pend_frame = din;
            end else ovr_pend = 1;
        end
    endtask

    task automatic rand_frame();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                din[r][c] = 16'($urandom);
    endtask

    task automatic fill_frame(input logic [15:0] v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                din[r][c] = v;
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        while ((pend || q.size() != 0) && k < 3000) begin
            step(0, rnd ? 1'($urandom % 2) : 1'b1);
            k++;
        end
        chk("drain_done", 16'(k < 3000), 16'd1);
    endtask

    task automatic run_until(input int left);
        int k = 0;
        while ((pend || q.size() != left) && k < 500) begin
            step(0, 1'b1);
            k++;
        end
        chk("reach_index", 16'(k < 500), 16'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 16'(m_valid), 16'd0);
        chk({tag, "_data"}, m_data, 16'd0);
        chk({tag, "_row"}, 16'(m_row), 16'd0);
        chk({tag, "_col"}, 16'(m_col), 16'd0);
        chk({tag, "_last"}, 16'(m_last), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_overrun"}, 16'(overrun), 16'd0);
    endtask

    always @(negedge clk) begin
        item_t e;
        chk("m_valid", 16'(m_valid), 16'(q.size() != 0));
        chk("busy", 16'(busy), 16'(q.size() != 0));
        chk("overrun", 16'(overrun), 16'(ovr_exp));
        if (stall_prev && m_valid) begin
            chk("hold_data", m_data, held.d);
            chk("hold_row", 16'(m_row), 16'(held.r));
            chk("hold_col", 16'(m_col), 16'(held.c));
            chk("hold_last", 16'(m_last), 16'(held.l));
        end
        if (m_valid && m_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("data", m_data, e.d);
            chk("row", 16'(m_row), 16'(e.r));
            chk("col", 16'(m_col), 16'(e.c));
            chk("last", 16'(m_last), 16'(e.l));
        end
        stall_prev = m_valid && !m_ready;
        held = '{d: m_data, r: m_row, c: m_col, l: m_last};
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fill_frame(16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                din[r][c] = 16'(r * 6 + c - 10);
        step(1, 1);
        step(0, 1);
        fill_frame(16'h7FFF);
        drain(0);
        for (int i = 0; i < 600; i++) begin
            logic s;
            s = ($urandom % 30 == 0);
            if (s) rand_frame();
            step(s, 1'($urandom % 2));
        end
        drain(1);
        rand_frame();
        step(1, 1);
        run_until(26);
        step(1, 1);
        step(0, 1);
        fill_frame(16'h7FFF);
        drain(0);
        rand_frame();
        step(1, 1);
        run_until(1);
        rand_frame();
        step(1, 1);
        step(0, 1);
        fill_frame(16'h8000);
        drain(0);
        rand_frame();
        step(1, 1);
        run_until(16);
        @(posedge clk);
        #1;
        reset = 0;
        in_st = 0;
        q.delete();
        pend = 0;
        ovr_pend = 0;
        ovr_exp = 0;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        rand_frame();
        step(1, 1);
        drain(0);
        step(0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
